// File: rtl/pipelined_reduction_tree.sv
// Pipelined adder tree reducing NUM_INPUTS words per beat, accumulating beat sums
// over in_last-delimited frames with saturating beat count and sticky overflow.
module pipelined_reduction_tree #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned ACC_BITS   = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [WORD_SIZE*NUM_INPUTS-1:0]                       in_data,
    input  logic                                                  in_last,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [WORD_SIZE+$clog2(NUM_INPUTS)+ACC_BITS-1:0]      out_sum,
    output logic [ACC_BITS:0]                                     out_count,
    output logic                                                  out_overflow
);

    localparam int unsigned LEVELS = $clog2(NUM_INPUTS);
    localparam int unsigned SUM_W  = WORD_SIZE + LEVELS;
    localparam int unsigned OUT_W  = SUM_W + ACC_BITS;
    localparam int unsigned CNT_W  = ACC_BITS + 1;
    localparam int unsigned NODES  = 2 * NUM_INPUTS;

    logic                 en;
    // Heap-ordered tree: node i sums nodes 2i and 2i+1; leaves at NUM_INPUTS..NODES-1.
    logic [SUM_W-1:0]     tree [1:NODES-1];
    logic [LEVELS:0]      vld;
    logic [LEVELS:0]      lst;

    logic [OUT_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;

    logic [OUT_W-1:0]     root_ext;
    logic [OUT_W:0]       sum_wide;
    logic [OUT_W-1:0]     acc_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ovf_hit;
    logic                 ovf_nxt;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    function automatic logic [SUM_W-1:0] ext_word(input logic [WORD_SIZE-1:0] w);
        if (SIGNED != 0) begin
            return {{LEVELS{w[WORD_SIZE-1]}}, w};
        end
        return {{LEVELS{1'b0}}, w};
    endfunction

    // Tree datapath: one level per stage, advancing only with the global enable.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                tree[int'(NUM_INPUTS) + i] <= ext_word(in_data[i*int'(WORD_SIZE) +: WORD_SIZE]);
            end
            for (int i = 1; i < int'(NUM_INPUTS); i++) begin
                tree[i] <= tree[2*i] + tree[2*i+1];
            end
        end
    end

    // Frame accumulation of the root sum.
    always_comb begin
        root_ext = {{ACC_BITS{1'b0}}, tree[1]};
        if (SIGNED != 0) begin
            root_ext = {{ACC_BITS{tree[1][SUM_W-1]}}, tree[1]};
        end
        sum_wide = {1'b0, acc} + {1'b0, root_ext};
        acc_nxt  = sum_wide[OUT_W-1:0];
        ovf_hit  = sum_wide[OUT_W];
        if (SIGNED != 0) begin
            ovf_hit = (acc[OUT_W-1] == root_ext[OUT_W-1]) && (acc_nxt[OUT_W-1] != acc[OUT_W-1]);
        end
        ovf_nxt  = ovf | ovf_hit;
        cnt_nxt  = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld          <= '0;
            lst          <= '0;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (en) begin
            vld       <= {vld[LEVELS-1:0], in_valid};
            lst       <= {lst[LEVELS-1:0], in_valid & in_last};
            out_valid <= vld[LEVELS] & lst[LEVELS];
            if (vld[LEVELS]) begin
                if (lst[LEVELS]) begin
                    out_sum      <= acc_nxt;
                    out_count    <= cnt_nxt;
                    out_overflow <= ovf_nxt;
                    acc          <= '0;
                    cnt          <= '0;
                    ovf          <= 1'b0;
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    ovf <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_reduction_tree.sv
// Bench: three lockstep instances (unsigned, signed, narrow accumulator) against a
// frame-level arithmetic model fed by directed and randomized beats.
module tb_pipelined_reduction_tree;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned DW = W * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready_u, in_ready_s, in_ready_n;
    logic          out_valid_u, out_valid_s, out_valid_n;
    logic [19:0]   out_sum_u, out_sum_s;
    logic [12:0]   out_sum_n;
    logic [8:0]    out_count_u, out_count_s;
    logic [1:0]    out_count_n;
    logic          out_overflow_u, out_overflow_s, out_overflow_n;

    always #5 clk = ~clk;

    pipelined_reduction_tree #(.WORD_SIZE(8), .NUM_INPUTS(16), .SIGNED(0), .ACC_BITS(8)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready), .out_sum(out_sum_u),
        .out_count(out_count_u), .out_overflow(out_overflow_u));

    pipelined_reduction_tree #(.WORD_SIZE(8), .NUM_INPUTS(16), .SIGNED(1), .ACC_BITS(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
        .out_count(out_count_s), .out_overflow(out_overflow_s));

    pipelined_reduction_tree #(.WORD_SIZE(8), .NUM_INPUTS(16), .SIGNED(0), .ACC_BITS(1)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_n), .out_ready(out_ready), .out_sum(out_sum_n),
        .out_count(out_count_n), .out_overflow(out_overflow_n));

    typedef struct packed {
        logic [2:0][63:0] s;
        logic [2:0][31:0] c;
        logic [2:0]       o;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    exp_t   chk_e;
    longint m_acc [3];
    int     m_cnt [3];
    bit     m_ovf [3];
    bit     rnd_ready = 1'b0;
    int     n_checks  = 0;
    int     n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ow(input int c);
        return (c == 2) ? 13 : 20;
    endfunction

    function automatic int cmax(input int c);
        return (c == 2) ? 3 : 511;
    endfunction

    function automatic longint beat_sum(input logic [DW-1:0] d, input bit sg);
        longint     s = 0;
        logic [W-1:0] w;
        for (int i = 0; i < int'(N); i++) begin
            w = d[i*int'(W) +: W];
            if (sg) s += longint'($signed(w));
            else    s += longint'(w);
        end
        return s;
    endfunction

    function automatic bit out_of_range(input longint v, input int c);
        longint lim = longint'(1) << ow(c);
        if (c == 1) return (v >= lim / 2) || (v < -(lim / 2));
        return v >= lim;
    endfunction

    // Model: true running frame sums; wrapped value, saturated count and sticky flag on last.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                m_acc[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
            end
            exp_q.delete();
        end else if (in_valid && in_ready_u) begin
            mon_e = '0;
            for (int c = 0; c < 3; c++) begin
                m_acc[c] += beat_sum(in_data, c == 1);
                m_cnt[c]++;
                if (out_of_range(m_acc[c], c)) m_ovf[c] = 1'b1;
                if (in_last) begin
                    mon_e.s[c] = 64'(m_acc[c] & ((longint'(1) << ow(c)) - 1));
                    mon_e.c[c] = 32'((m_cnt[c] > cmax(c)) ? cmax(c) : m_cnt[c]);
                    mon_e.o[c] = m_ovf[c];
                    m_acc[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
                end
            end
            if (in_last) exp_q.push_back(mon_e);
        end
    end

    // Every cycle a result is presented it must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rst_n && out_valid_u) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(1), 64'(0));
            end else begin
                chk_e = exp_q[0];
                check("valid_s", 64'(out_valid_s), 64'(1));
                check("valid_n", 64'(out_valid_n), 64'(1));
                check("sum_u",   64'(out_sum_u),      chk_e.s[0]);
                check("cnt_u",   64'(out_count_u),    64'(chk_e.c[0]));
                check("ovf_u",   64'(out_overflow_u), 64'(chk_e.o[0]));
                check("sum_s",   64'(out_sum_s),      chk_e.s[1]);
                check("cnt_s",   64'(out_count_s),    64'(chk_e.c[1]));
                check("ovf_s",   64'(out_overflow_s), 64'(chk_e.o[1]));
                check("sum_n",   64'(out_sum_n),      chk_e.s[2]);
                check("cnt_n",   64'(out_count_n),    64'(chk_e.c[2]));
                check("ovf_n",   64'(out_overflow_n), 64'(chk_e.o[2]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
    end

    function automatic logic [DW-1:0] fill(input logic [W-1:0] b);
        return {N{b}};
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok;
        int guard;
        in_valid = 1'b1; in_data = d; in_last = l; guard = 0;
        do begin
            @(negedge clk);
            ok = in_ready_u;
            @(posedge clk); #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid_u), 64'(0));
        check({tag, "_sum_u"}, 64'(out_sum_u), 64'(0));
        check({tag, "_cnt_u"}, 64'(out_count_u), 64'(0));
        check({tag, "_ovf_n"}, 64'(out_overflow_n), 64'(0));
        check({tag, "_sum_s"}, 64'(out_sum_s), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready_u), 64'(1));
    endtask

    initial begin
        int          lat;
        int          g;
        logic [DW-1:0] d;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single all-0xFF beat: latency from accepting edge to out_valid.
        in_valid = 1'b1; in_data = fill(8'hFF); in_last = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin in_valid = 1'b0; in_last = 1'b0; end
        end while (!out_valid_u && lat < 20);
        check("latency", 64'(lat), 64'(6));
        idle(3);

        for (int i = 0; i < int'(N); i++) d[i*int'(W) +: W] = (i % 2 != 0) ? 8'h7F : 8'h80;
        send(d, 1'b1);
        idle(8);

        repeat (2) send(fill(8'h01), 1'b0);
        send(fill(8'h01), 1'b1);
        send(fill(8'h01), 1'b1);
        idle(8);

        repeat (2) send(fill(8'hFF), 1'b0);
        send(fill(8'hFF), 1'b1);
        send(fill(8'h03), 1'b1);
        repeat (4) send(fill(8'h10), 1'b0);
        send(fill(8'h10), 1'b1);
        idle(10);

        // Back-to-back single-beat frames with a 5-cycle downstream stall.
        fork
            begin
                repeat (4) send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
                idle(1);
            end
            begin
                g = 0;
                while (!out_valid_u && g < 50) begin @(negedge clk); g++; end
                check("stall_seen_valid", 64'(out_valid_u), 64'(1));
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready_u), 64'(0));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(12);
        check("stall_drained", 64'(exp_q.size()), 64'(0));

        // Reset mid-frame discards the partial frame.
        repeat (2) send(fill(8'h05), 1'b0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(fill(8'h02), 1'b1);
        idle(10);

        rnd_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) d = fill(8'hFF);
            else d = {$urandom, $urandom, $urandom, $urandom};
            send(d, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(30);
        check("final_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
